pc_fetch_stage: RTL and testbench

- Instruction-fetch stage directly upstream of stall_control_block.
- Holds the program counter (PC), drives the program-memory address, and latches fetched words into the IF/ID instruction register.
- Presents the registered opcode (ir[31:26]) as `op` to stall_control_block.
- Consumes that block's stall/stall_pm, plus jump redirects from decode.

---
 rtl/pc_fetch_stage_pkg.sv | 23 ++
 rtl/pc_fetch_stage_pc_register.sv | 23 ++
 rtl/pc_fetch_stage.sv | 109 ++++++++++
 tb/tb_pc_fetch_stage.sv | 169 ++++++++++++++++
 4 files changed

// File: rtl/pc_fetch_stage_pkg.sv
// Shared opcode constants, fetch FSM encoding and NOP word for the fetch stage.
// HALT_DETECT_EN adds the HALT state to the FSM encoding.
package pc_fetch_stage_pkg;

    localparam logic [5:0] OP_NOP = 6'b000000;
    localparam logic [5:0] OP_HLT = 6'b010001;

    // Opcodes that stall_control_block decodes as hazard sources.
    localparam logic [5:0] OP_LW  = 6'b100011;
    localparam logic [5:0] OP_JMP = 6'b000010;
    localparam logic [5:0] OP_BEQ = 6'b000100;

    localparam logic [31:0] NOP_WORD = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_FETCH = 2'b00,
        ST_FLUSH = 2'b01
`ifdef HALT_DETECT_EN
       ,ST_HALT  = 2'b10
`endif
    } fetch_state_t;

endpackage

// File: rtl/pc_fetch_stage_pc_register.sv
// Program counter: loadable, holdable, wrapping up-counter with async active-low reset.
module pc_fetch_stage_pc_register #(
    parameter int              AW       = 16,
    parameter logic [AW-1:0]   RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          load,
    input  logic [AW-1:0] load_val,
    input  logic          inc,
    output logic [AW-1:0] pc
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            pc <= RESET_PC;
        else if (load)
            pc <= load_val;
        else if (inc)
            pc <= pc + 1'b1;
    end

endmodule

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC, program-memory address and IF/ID register feeding stall_control_block.
// Define HALT_DETECT_EN to freeze the stage once an HLT instruction is fetched.
module pc_fetch_stage
    import pc_fetch_stage_pkg::*;
#(
    parameter int            AW       = 16,
    parameter int            IW       = 32,
    parameter logic [AW-1:0] RESET_PC = '0
) (
    input  logic          clk,
    input  logic          reset,
    output logic [AW-1:0] pm_addr,
    input  logic [IW-1:0] pm_data,
    input  logic          stall,
    input  logic          stall_pm,
    input  logic          jump_en,
    input  logic [AW-1:0] jump_addr,
    output logic [IW-1:0] ir,
    output logic [5:0]    op,
    output logic          ir_valid,
    output logic [AW-1:0] pc_plus1
);

    localparam logic [IW-1:0] NOP = IW'(NOP_WORD);

    fetch_state_t  state, state_d;
    logic [AW-1:0] pc;
    logic          pc_load, pc_inc;
    logic [IW-1:0] ir_d;
    logic          vld_d;
    logic [AW-1:0] p1_d;

    pc_fetch_stage_pc_register #(
        .AW       (AW),
        .RESET_PC (RESET_PC)
    ) u_pc (
        .clk      (clk),
        .reset    (reset),
        .load     (pc_load),
        .load_val (jump_addr),
        .inc      (pc_inc),
        .pc       (pc)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= ST_FETCH;
            ir       <= NOP;
            ir_valid <= 1'b0;
            pc_plus1 <= '0;
        end else begin
            state    <= state_d;
            ir       <= ir_d;
            ir_valid <= vld_d;
            pc_plus1 <= p1_d;
        end
    end

    always_comb begin
        state_d = state;
        ir_d    = ir;
        vld_d   = ir_valid;
        p1_d    = pc_plus1;
        pc_load = 1'b0;
        pc_inc  = 1'b0;
        unique case (state)
            ST_FETCH: begin
                if (jump_en) begin
                    pc_load = 1'b1;
                    ir_d    = NOP;
                    vld_d   = 1'b0;
                    state_d = ST_FLUSH;
                end else if (stall) begin
                    // full hold: stall dominates stall_pm
                end else if (stall_pm) begin
                    ir_d    = NOP;
                    vld_d   = 1'b0;
                end else begin
                    ir_d    = pm_data;
                    vld_d   = 1'b1;
                    p1_d    = pc + 1'b1;
                    pc_inc  = 1'b1;
`ifdef HALT_DETECT_EN
                    if (pm_data[IW-1:IW-6] == OP_HLT)
                        state_d = ST_HALT;
`endif
                end
            end
            ST_FLUSH: begin
                // Redirect target is already in PC; spend one bubble while memory catches up.
                if (!stall) begin
                    ir_d    = NOP;
                    vld_d   = 1'b0;
                    state_d = ST_FETCH;
                end
            end
`ifdef HALT_DETECT_EN
            ST_HALT: begin
                vld_d = 1'b0;
            end
`endif
            default: state_d = ST_FETCH;
        endcase
    end

    assign pm_addr = pc;
    assign op      = ir[IW-1:IW-6];

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Self-checking bench for pc_fetch_stage: directed scenarios plus randomized control, against a behavioural model.
module tb_pc_fetch_stage;

    localparam int AW = 16;
    localparam int IW = 32;
    localparam logic [AW-1:0] HLT_ADDR = 16'h0040;

    logic          clk = 1'b0;
    logic          reset;
    logic [AW-1:0] pm_addr;
    logic [IW-1:0] pm_data;
    logic          stall, stall_pm, jump_en;
    logic [AW-1:0] jump_addr;
    logic [IW-1:0] ir;
    logic [5:0]    op;
    logic          ir_valid;
    logic [AW-1:0] pc_plus1;

    int checks   = 0;
    int failures = 0;

    // behavioural model
    logic [AW-1:0] m_pc, m_p1;
    logic [IW-1:0] m_ir;
    logic          m_vld;
    bit            m_flush, m_halted;

    always #5 clk = ~clk;

    pc_fetch_stage #(.AW(AW), .IW(IW), .RESET_PC('0)) dut (
        .clk       (clk),
        .reset     (reset),
        .pm_addr   (pm_addr),
        .pm_data   (pm_data),
        .stall     (stall),
        .stall_pm  (stall_pm),
        .jump_en   (jump_en),
        .jump_addr (jump_addr),
        .ir        (ir),
        .op        (op),
        .ir_valid  (ir_valid),
        .pc_plus1  (pc_plus1)
    );

    function automatic logic [IW-1:0] mem(input logic [AW-1:0] a);
        logic [IW-1:0] w;
        if (a == HLT_ADDR) return 32'h4400_0000;
        w = (32'(a) * 32'h9E37_79B1) ^ 32'h5A5A_1234;
        if (w[31:26] == 6'b010001) w[31:26] = 6'b010010;
        return w;
    endfunction

    assign pm_data = mem(pm_addr);

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        check({tag, ".pm_addr"},  64'(pm_addr),  64'(m_pc));
        check({tag, ".ir"},       64'(ir),       64'(m_ir));
        check({tag, ".op"},       64'(op),       64'(m_ir[31:26]));
        check({tag, ".ir_valid"}, 64'(ir_valid), 64'(m_vld));
        check({tag, ".pc_plus1"}, 64'(pc_plus1), 64'(m_p1));
    endtask

    task automatic model_reset();
        m_pc = '0; m_p1 = '0; m_ir = '0; m_vld = 1'b0;
        m_flush = 0; m_halted = 0;
    endtask

    // One clock: drive controls, advance the model by the stage's rules, check #1 after the edge.
    task automatic step(input string tag, input bit s, input bit spm, input bit j, input logic [AW-1:0] ja);
        logic [IW-1:0] w;
        stall = s; stall_pm = spm; jump_en = j; jump_addr = ja;
        if (m_halted) begin
            m_vld = 1'b0;
        end else if (m_flush) begin
            if (!s) begin m_ir = '0; m_vld = 1'b0; m_flush = 0; end
        end else if (j) begin
            m_pc = ja; m_ir = '0; m_vld = 1'b0; m_flush = 1;
        end else if (s) begin
        end else if (spm) begin
            m_ir = '0; m_vld = 1'b0;
        end else begin
            w = mem(m_pc);
            m_ir = w; m_vld = 1'b1; m_p1 = m_pc + 1'b1; m_pc = m_pc + 1'b1;
`ifdef HALT_DETECT_EN
            if (w[31:26] == 6'b010001) m_halted = 1;
`endif
        end
        @(posedge clk); #1;
        check_all(tag);
    endtask

    initial begin
        reset = 1'b0; stall = 0; stall_pm = 0; jump_en = 0; jump_addr = '0;
        model_reset();
        #2 check_all("reset");
        @(posedge clk); #1 reset = 1'b1;

        // straight-line fetch, then stall at PC=3
        for (int i = 0; i < 3; i++) step("fetch", 0, 0, 0, '0);
        check("pc_at_3", 64'(pm_addr), 64'd3);
        step("stall", 1, 0, 0, '0);
        step("stall", 1, 1, 0, '0);
        step("release", 0, 0, 0, '0);
        check("ir_mem3", 64'(ir), 64'(mem(16'd3)));
        step("stall_pm", 0, 1, 0, '0);
        step("after_pm", 0, 0, 0, '0);
        check("ir_mem4", 64'(ir), 64'(mem(16'd4)));

        // asynchronous reset mid-run at PC=5
        check("pc_at_5", 64'(pm_addr), 64'd5);
        #3 reset = 1'b0;
        model_reset();
        #1 check_all("async_reset");
        @(posedge clk); #1 check_all("reset_hold");
        reset = 1'b1;

        // walk to PC=7, then jump while stalled
        for (int i = 0; i < 7; i++) step("refetch", 0, 0, 0, '0);
        step("jump_stall", 1, 1, 1, 16'h0020);
        step("flush", 0, 0, 1, 16'h0099);
        step("tgt", 0, 0, 0, '0);
        check("ir_mem20", 64'(ir), 64'(mem(16'h0020)));

        // stall held during FLUSH
        step("jump2", 0, 0, 1, 16'h0100);
        step("flush_stall", 1, 0, 0, '0);
        step("flush_rel", 0, 0, 0, '0);
        step("tgt2", 0, 0, 0, '0);

        // randomized control
        for (int i = 0; i < 300; i++) begin
            step("rand", ($urandom_range(99) < 20), ($urandom_range(99) < 15),
                 ($urandom_range(99) < 8), AW'($urandom));
        end

        // PC wrap at all-ones
        reset = 1'b0; model_reset(); #1 check_all("reset2");
        @(posedge clk); #1 reset = 1'b1;
        step("j_ffff", 0, 0, 1, 16'hFFFF);
        step("flush_ffff", 0, 0, 0, '0);
        step("wrap", 0, 0, 0, '0);
        check("wrap_pc", 64'(pm_addr), 64'd0);
        check("wrap_p1", 64'(pc_plus1), 64'd0);

        // HLT word fetch (halts only with HALT_DETECT_EN)
        step("j_hlt", 0, 0, 1, HLT_ADDR);
        step("flush_hlt", 0, 0, 0, '0);
        step("hlt_fetch", 0, 0, 0, '0);
        check("hlt_ir", 64'(ir), 64'h4400_0000);
        step("hlt_jump", 0, 0, 1, 16'h0080);
        step("hlt_stall", 1, 1, 0, '0);
        for (int i = 0; i < 3; i++) step("hlt_run", 0, 0, 0, '0);
        reset = 1'b0; model_reset(); #1 check_all("reset3");
        @(posedge clk); #1 reset = 1'b1;
        step("post_reset", 0, 0, 0, '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
